// File: rtl/cnn_fifo_delay_param_pkg.sv
// ============================================================================
// Module  : cnn_fifo_delay_param_pkg
// Brief   : Shared mode constants, flag bundle and flag helper for the FIFO.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package cnn_fifo_delay_param_pkg;

  localparam int FIFO_MODE_REG  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_flags_t;

  localparam fifo_flags_t C_FLAGS_RESET = '{full: 1'b0, empty: 1'b1,
                                            almost_full: 1'b0, almost_empty: 1'b1};

  // An AF level above the depth can never be reached, so almost_full stays low.
  function automatic fifo_flags_t flags_from_count(input int cnt, input int depth,
                                                   input int af, input int ae);
    fifo_flags_t f;
    f.full         = (cnt == depth);
    f.empty        = (cnt == 0);
    f.almost_full  = (cnt >= af);
    f.almost_empty = (cnt <= ae);
    return f;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cnn_fifo_param_ctrl.sv
// ============================================================================
// Module  : cnn_fifo_param_ctrl
// Brief   : Pointer, occupancy, status-flag and sticky-error control for the FIFO.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module cnn_fifo_param_ctrl
  import cnn_fifo_delay_param_pkg::*;
#(
  parameter int DATA_DEPTH    = 13,
  parameter int POINTER_WIDTH = 4,
  parameter int COUNT_WIDTH   = 5,
  parameter int AF_LEVEL      = 11,
  parameter int AE_LEVEL      = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     write,
  input  logic                     read,
  output logic                     wr_en,
  output logic                     rd_en,
  output logic [POINTER_WIDTH-1:0] wr_ptr,
  output logic [POINTER_WIDTH-1:0] rd_ptr,
  output logic [COUNT_WIDTH-1:0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic                     overflow,
  output logic                     underflow
);

  logic [POINTER_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [COUNT_WIDTH-1:0]   count_q, count_d;
  fifo_flags_t              flags_q, flags_d;
  logic                     overflow_q, overflow_d, underflow_q, underflow_d;

  // Explicit compare-and-zero wrap so non-power-of-two depths work.
  function automatic logic [POINTER_WIDTH-1:0] ptr_inc(input logic [POINTER_WIDTH-1:0] p);
    return (p == POINTER_WIDTH'(DATA_DEPTH - 1)) ? '0 : p + POINTER_WIDTH'(1);
  endfunction

  always_comb begin
    wr_en       = write & ~flags_q.full & ~clear;
    rd_en       = read & ~flags_q.empty & ~clear;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q | (write & flags_q.full);
    underflow_d = underflow_q | (read & flags_q.empty);
    if (clear) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_en) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (rd_en) rd_ptr_d = ptr_inc(rd_ptr_q);
      if (wr_en && !rd_en)      count_d = count_q + COUNT_WIDTH'(1);
      else if (rd_en && !wr_en) count_d = count_q - COUNT_WIDTH'(1);
    end
    flags_d = flags_from_count(32'(count_d), DATA_DEPTH, AF_LEVEL, AE_LEVEL);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      flags_q     <= C_FLAGS_RESET;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      flags_q     <= flags_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign wr_ptr       = wr_ptr_q;
  assign rd_ptr       = rd_ptr_q;
  assign count        = count_q;
  assign full         = flags_q.full;
  assign empty        = flags_q.empty;
  assign almost_full  = flags_q.almost_full;
  assign almost_empty = flags_q.almost_empty;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

`default_nettype wire

// File: rtl/cnn_fifo_delay_param.sv
// ============================================================================
// Module  : cnn_fifo_delay_param
// Brief   : Parametrised delay FIFO with registered-read or FWFT output mode.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module cnn_fifo_delay_param
  import cnn_fifo_delay_param_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int DATA_DEPTH    = 13,
  parameter int POINTER_WIDTH = 4,
  parameter int COUNT_WIDTH   = 5,
  parameter int AF_LEVEL      = 11,
  parameter int AE_LEVEL      = 2,
  parameter int FWFT          = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   write,
  input  logic                   read,
  input  logic [DATA_WIDTH-1:0]  data_in,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic                   valid_out,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   overflow,
  output logic                   underflow
);

  logic                     wr_en, rd_en;
  logic [POINTER_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0]    mem_q [DATA_DEPTH];

  cnn_fifo_param_ctrl #(
    .DATA_DEPTH   (DATA_DEPTH),
    .POINTER_WIDTH(POINTER_WIDTH),
    .COUNT_WIDTH  (COUNT_WIDTH),
    .AF_LEVEL     (AF_LEVEL),
    .AE_LEVEL     (AE_LEVEL)
  ) u_ctrl (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .write       (write),
    .read        (read),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .wr_ptr      (wr_ptr),
    .rd_ptr      (rd_ptr),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr] <= data_in;
  end

  if (FWFT == FIFO_MODE_REG) begin : g_reg
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  valid_out_q, valid_out_d;

    always_comb begin
      data_out_d  = data_out_q;
      valid_out_d = 1'b0;
      if (rd_en) begin
        data_out_d  = mem_q[rd_ptr];
        valid_out_d = 1'b1;
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        data_out_q  <= '0;
        valid_out_q <= 1'b0;
      end else begin
        data_out_q  <= data_out_d;
        valid_out_q <= valid_out_d;
      end
    end

    assign data_out  = data_out_q;
    assign valid_out = valid_out_q;
  end else begin : g_fwft
    // Head word is shown only while occupied, so reset/empty present zero.
    assign data_out  = empty ? '0 : mem_q[rd_ptr];
    assign valid_out = 1'b0;
  end

endmodule

`default_nettype wire

// File: tb/tb_cnn_fifo_delay_param.sv
// ============================================================================
// Module  : tb_cnn_fifo_delay_param
// Brief   : Queue-model bench driving registered-read and FWFT FIFOs in lockstep.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cnn_fifo_delay_param;

  localparam int DW = 32;
  localparam int DEPTH = 13;
  localparam int CW = 5;
  localparam int AF = 11;
  localparam int AE = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          clear = 1'b0;
  logic          write = 1'b0;
  logic          read = 1'b0;
  logic [DW-1:0] data_in = '0;

  logic [DW-1:0] r_dout, f_dout;
  logic          r_vout, f_vout, r_full, f_full, r_empty, f_empty;
  logic          r_af, f_af, r_ae, f_ae, r_ovf, f_ovf, r_unf, f_unf;
  logic [CW-1:0] r_count, f_count;

  int n_chk = 0;
  int n_fail = 0;
  bit model_on = 1'b0;

  always #5 clk = ~clk;

  cnn_fifo_delay_param #(.FWFT(0)) dut_r (
    .clk(clk), .reset(reset), .clear(clear), .write(write), .read(read),
    .data_in(data_in), .data_out(r_dout), .valid_out(r_vout), .full(r_full),
    .empty(r_empty), .almost_full(r_af), .almost_empty(r_ae), .count(r_count),
    .overflow(r_ovf), .underflow(r_unf)
  );

  cnn_fifo_delay_param #(.FWFT(1)) dut_f (
    .clk(clk), .reset(reset), .clear(clear), .write(write), .read(read),
    .data_in(data_in), .data_out(f_dout), .valid_out(f_vout), .full(f_full),
    .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
    .overflow(f_ovf), .underflow(f_unf)
  );

  // Reference: an ordered queue of stored words plus sticky error bits.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout = '0;
  bit m_vout = 1'b0, m_ovf = 1'b0, m_unf = 1'b0;
  int n;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q.delete();
      m_ovf = 1'b0; m_unf = 1'b0; m_dout = '0; m_vout = 1'b0;
    end else if (clear) begin
      q.delete();
      m_ovf = 1'b0; m_unf = 1'b0; m_vout = 1'b0;
    end else begin
      n = q.size();
      if (write && n == DEPTH) m_ovf = 1'b1;
      if (read && n == 0) m_unf = 1'b1;
      if (read && n > 0) begin
        m_dout = q.pop_front();
        m_vout = 1'b1;
      end else begin
        m_vout = 1'b0;
      end
      if (write && n < DEPTH) q.push_back(data_in);
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_on) begin
      chk("r_count", 64'(r_count), 64'(q.size()));
      chk("r_full", 64'(r_full), 64'(q.size() == DEPTH));
      chk("r_empty", 64'(r_empty), 64'(q.size() == 0));
      chk("r_af", 64'(r_af), 64'(q.size() >= AF));
      chk("r_ae", 64'(r_ae), 64'(q.size() <= AE));
      chk("r_ovf", 64'(r_ovf), 64'(m_ovf));
      chk("r_unf", 64'(r_unf), 64'(m_unf));
      chk("r_dout", 64'(r_dout), 64'(m_dout));
      chk("r_vout", 64'(r_vout), 64'(m_vout));
      chk("f_count", 64'(f_count), 64'(q.size()));
      chk("f_full", 64'(f_full), 64'(q.size() == DEPTH));
      chk("f_empty", 64'(f_empty), 64'(q.size() == 0));
      chk("f_af", 64'(f_af), 64'(q.size() >= AF));
      chk("f_ae", 64'(f_ae), 64'(q.size() <= AE));
      chk("f_ovf", 64'(f_ovf), 64'(m_ovf));
      chk("f_unf", 64'(f_unf), 64'(m_unf));
      chk("f_vout", 64'(f_vout), 64'(0));
      if (q.size() > 0) chk("f_head", 64'(f_dout), 64'(q[0]));
    end
  end

  task automatic cyc(input logic w, input logic r, input logic c, input logic [DW-1:0] d);
    write = w; read = r; clear = c; data_in = d;
    @(posedge clk);
    #1;
    write = 1'b0; read = 1'b0; clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    model_on = 1'b1;
    chk("rst_count", 64'(r_count), 64'd0);
    chk("rst_empty", 64'(r_empty), 64'd1);
    chk("rst_ae", 64'(r_ae), 64'd1);
    chk("rst_full", 64'(r_full), 64'd0);
    chk("rst_dout", 64'(r_dout), 64'd0);
    chk("rst_vout", 64'(r_vout), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b1, 1'b0, 1'b0, DW'(32'h100 + i));
      chk("fill_af", 64'(r_af), 64'(i + 1 >= 11));
    end
    chk("fill_count", 64'(r_count), 64'd13);
    chk("fill_full", 64'(r_full), 64'd1);
    cyc(1'b1, 1'b0, 1'b0, 32'h1FF);
    chk("ovf_set", 64'(r_ovf), 64'd1);
    chk("ovf_count", 64'(r_count), 64'd13);

    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b0, 1'b1, 1'b0, '0);
      chk("drain_data", 64'(r_dout), 64'(32'h100 + i));
      chk("drain_valid", 64'(r_vout), 64'd1);
    end
    chk("drain_empty", 64'(r_empty), 64'd1);
    cyc(1'b0, 1'b1, 1'b0, '0);
    chk("unf_set", 64'(r_unf), 64'd1);
    chk("unf_dout", 64'(r_dout), 64'h10C);
    chk("unf_vout", 64'(r_vout), 64'd0);

    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, DW'(32'h200 + i));
    for (int i = 0; i < 40; i++) cyc(1'b1, 1'b1, 1'b0, DW'(32'h300 + i));
    chk("stream_count", 64'(r_count), 64'd5);
    chk("stream_dout", 64'(r_dout), 64'h322);

    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b0, DW'(32'h400 + i));
    cyc(1'b1, 1'b0, 1'b0, 32'h4FF);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b0, '0);
    chk("pre_clr_count", 64'(r_count), 64'd7);
    chk("pre_clr_ovf", 64'(r_ovf), 64'd1);
    cyc(1'b1, 1'b0, 1'b1, 32'hDEAD);
    chk("clr_count", 64'(r_count), 64'd0);
    chk("clr_empty", 64'(r_empty), 64'd1);
    chk("clr_ovf", 64'(r_ovf), 64'd0);
    chk("clr_vout", 64'(r_vout), 64'd0);
    cyc(1'b1, 1'b0, 1'b0, 32'hBEEF);
    cyc(1'b0, 1'b1, 1'b0, '0);
    chk("post_clr_data", 64'(r_dout), 64'hBEEF);

    cyc(1'b1, 1'b0, 1'b0, 32'hAA);
    chk("fwft_empty", 64'(f_empty), 64'd0);
    chk("fwft_data", 64'(f_dout), 64'hAA);
    @(posedge clk); #1;
    chk("fwft_hold", 64'(f_dout), 64'hAA);
    cyc(1'b0, 1'b1, 1'b0, '0);
    chk("fwft_popped", 64'(f_empty), 64'd1);

    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 1'b0, DW'(32'h500 + i));
    chk("burst_count", 64'(r_count), 64'd6);
    write = 1'b1; data_in = 32'h5FF;
    #2 reset = 1'b0;
    #1;
    chk("arst_count", 64'(r_count), 64'd0);
    chk("arst_empty", 64'(r_empty), 64'd1);
    chk("arst_full", 64'(r_full), 64'd0);
    chk("arst_ovf", 64'(r_ovf), 64'd0);
    chk("arst_dout", 64'(r_dout), 64'd0);
    chk("arst_f_empty", 64'(f_empty), 64'd1);
    write = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 32'h777);
    chk("rst_new_f", 64'(f_dout), 64'h777);
    cyc(1'b0, 1'b1, 1'b0, '0);
    chk("rst_new_r", 64'(r_dout), 64'h777);
    chk("rst_new_empty", 64'(r_empty), 64'd1);

    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
